// File: rtl/blink_mon_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// blink_mon_pkg: shared types and constants for the blink monitor.
// Rev 1.0
// ----------------------------------------------------------------------------
package blink_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } mon_state_e;

  localparam int c_ERR_CNT_W = 8;

endpackage
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sync_edge_det: 2-FF synchronizer plus delay register with rise/fall strobes.
// Rev 1.0
// ----------------------------------------------------------------------------
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule
`default_nettype wire

// File: rtl/blink_monitor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// blink_monitor: measures lamp half-periods, checks tolerance, flags stuck lamp.
// Rev 1.0
// ----------------------------------------------------------------------------
module blink_monitor
  import blink_mon_pkg::*;
#(
  parameter int HALF_CYC  = 50,
  parameter int TOL_CYC   = 2,
  parameter int STUCK_CYC = 200,
  parameter int CNT_W     = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   light_i,
  input  logic                   check_en_i,
  output logic                   ok_o,
  output logic                   stuck_on_o,
  output logic                   stuck_off_o,
  output logic [CNT_W-1:0]       period_o,
  output logic                   period_valid_o,
  output logic [c_ERR_CNT_W-1:0] err_cnt_o
);

  localparam logic [CNT_W-1:0]       c_LEN_MIN  = CNT_W'(HALF_CYC - TOL_CYC);
  localparam logic [CNT_W-1:0]       c_LEN_MAX  = CNT_W'(HALF_CYC + TOL_CYC);
  localparam logic [CNT_W-1:0]       c_STUCK    = CNT_W'(STUCK_CYC);
  localparam logic [CNT_W-1:0]       c_STUCK_M1 = CNT_W'(STUCK_CYC - 1);
  localparam logic [CNT_W-1:0]       c_ONE      = CNT_W'(1);
  localparam logic [c_ERR_CNT_W-1:0] c_ERR_MAX  = '1;
  localparam logic [c_ERR_CNT_W-1:0] c_ERR_ONE  = c_ERR_CNT_W'(1);

  function automatic logic out_of_tol(input logic [CNT_W-1:0] len);
    return (len < c_LEN_MIN) || (len > c_LEN_MAX);
  endfunction

  logic w_sync, w_rise, w_fall;

  sync_edge_det u_sync (
    .clk    (clk_i),
    .rst    (rst_i),
    .i_d    (light_i),
    .o_sync (w_sync),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  mon_state_e             r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0]       r_high_len, w_high_len_nxt;
  logic                   r_high_viol, w_high_viol_nxt;
  logic                   r_ok, w_ok_nxt;
  logic                   r_stuck_on, w_stuck_on_nxt;
  logic                   r_stuck_off, w_stuck_off_nxt;
  logic [CNT_W-1:0]       r_period, w_period_nxt;
  logic                   r_valid, w_valid_nxt;
  logic [c_ERR_CNT_W-1:0] r_err, w_err_nxt;
  logic                   w_err_inc;
  logic                   w_low_viol;

  assign w_low_viol = out_of_tol(r_cnt);

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_high_len_nxt  = r_high_len;
    w_high_viol_nxt = r_high_viol;
    w_ok_nxt        = r_ok;
    w_stuck_on_nxt  = r_stuck_on;
    w_stuck_off_nxt = r_stuck_off;
    w_period_nxt    = r_period;
    w_valid_nxt     = 1'b0;
    w_err_inc       = 1'b0;

    if (!check_en_i) begin
      // Disable overrides everything, including a coincident rise.
      w_state_nxt     = ST_IDLE;
      w_cnt_nxt       = '0;
      w_ok_nxt        = 1'b0;
      w_stuck_on_nxt  = 1'b0;
      w_stuck_off_nxt = 1'b0;
    end else begin
      if (w_rise) begin
        w_stuck_on_nxt  = 1'b0;
        w_stuck_off_nxt = 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_ALIGN;
          w_cnt_nxt   = '0;
        end
        ST_ALIGN: begin
          if (w_rise) begin
            w_state_nxt = ST_HIGH;
            w_cnt_nxt   = c_ONE;
          end else if (w_fall) begin
            w_cnt_nxt = c_ONE;
          end else if (w_sync) begin
            w_cnt_nxt = '0;
          end else if (r_cnt == c_STUCK_M1) begin
            w_stuck_off_nxt = 1'b1;
            w_ok_nxt        = 1'b0;
            w_err_inc       = 1'b1;
            w_cnt_nxt       = c_STUCK;
          end else if (r_cnt < c_STUCK) begin
            w_cnt_nxt = r_cnt + c_ONE;
          end
        end
        ST_HIGH: begin
          if (w_fall) begin
            w_high_len_nxt  = r_cnt;
            w_high_viol_nxt = out_of_tol(r_cnt);
            w_err_inc       = out_of_tol(r_cnt);
            w_state_nxt     = ST_LOW;
            w_cnt_nxt       = c_ONE;
          end else if (r_cnt == c_STUCK_M1) begin
            w_stuck_on_nxt = 1'b1;
            w_ok_nxt       = 1'b0;
            w_err_inc      = 1'b1;
            w_cnt_nxt      = c_STUCK;
            w_state_nxt    = ST_ALIGN;
          end else begin
            w_cnt_nxt = r_cnt + c_ONE;
          end
        end
        ST_LOW: begin
          if (w_rise) begin
            w_period_nxt = r_high_len + r_cnt;
            w_valid_nxt  = 1'b1;
            w_ok_nxt     = !(r_high_viol || w_low_viol);
            w_err_inc    = w_low_viol;
            w_state_nxt  = ST_HIGH;
            w_cnt_nxt    = c_ONE;
          end else if (r_cnt == c_STUCK_M1) begin
            w_stuck_off_nxt = 1'b1;
            w_ok_nxt        = 1'b0;
            w_err_inc       = 1'b1;
            w_cnt_nxt       = c_STUCK;
            w_state_nxt     = ST_ALIGN;
          end else begin
            w_cnt_nxt = r_cnt + c_ONE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end

    w_err_nxt = (w_err_inc && (r_err != c_ERR_MAX)) ? r_err + c_ERR_ONE : r_err;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_high_len  <= '0;
      r_high_viol <= 1'b0;
      r_ok        <= 1'b0;
      r_stuck_on  <= 1'b0;
      r_stuck_off <= 1'b0;
      r_period    <= '0;
      r_valid     <= 1'b0;
      r_err       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_high_len  <= w_high_len_nxt;
      r_high_viol <= w_high_viol_nxt;
      r_ok        <= w_ok_nxt;
      r_stuck_on  <= w_stuck_on_nxt;
      r_stuck_off <= w_stuck_off_nxt;
      r_period    <= w_period_nxt;
      r_valid     <= w_valid_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign ok_o           = r_ok;
  assign stuck_on_o     = r_stuck_on;
  assign stuck_off_o    = r_stuck_off;
  assign period_o       = r_period;
  assign period_valid_o = r_valid;
  assign err_cnt_o      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_blink_monitor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_blink_monitor: table vectors, corner sequences and random waves vs model.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_blink_monitor;

  localparam int HALF  = 50;
  localparam int TOL   = 2;
  localparam int STUCK = 200;
  localparam int W     = 16;

  logic         clk = 1'b0;
  logic         rst_i, light_i, check_en_i;
  logic         ok_o, stuck_on_o, stuck_off_o, period_valid_o;
  logic [W-1:0] period_o;
  logic [7:0]   err_cnt_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  blink_monitor #(
    .HALF_CYC  (HALF),
    .TOL_CYC   (TOL),
    .STUCK_CYC (STUCK),
    .CNT_W     (W)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .light_i        (light_i),
    .check_en_i     (check_en_i),
    .ok_o           (ok_o),
    .stuck_on_o     (stuck_on_o),
    .stuck_off_o    (stuck_off_o),
    .period_o       (period_o),
    .period_valid_o (period_valid_o),
    .err_cnt_o      (err_cnt_o)
  );

  // Reference model: run length of the synchronized level plus alignment flags.
  bit m_l1, m_l2, m_l3, m_active, m_aligned, m_have_hi, m_hi_bad;
  bit m_ok, m_son, m_soff, m_valid;
  int m_run, m_hi, m_period, m_err;

  int n_pulse, cap_period, cap_ok, cap_err;

  function automatic bit oot(input int len);
    return (len > HALF + TOL) || (len < HALF - TOL);
  endfunction

  task automatic bump_err();
    if (m_err < 255) m_err++;
  endtask

  task automatic model_edge(input bit r, input bit l, input bit e);
    bit s, p, b;
    s = m_l2;
    p = m_l3;
    m_valid = 1'b0;
    if (r) begin
      {m_active, m_aligned, m_have_hi, m_hi_bad, m_ok, m_son, m_soff} = '0;
      m_run = 0; m_hi = 0; m_period = 0; m_err = 0;
    end else if (!e) begin
      {m_active, m_aligned, m_have_hi, m_ok, m_son, m_soff} = '0;
    end else if (!m_active) begin
      m_active = 1'b1; m_aligned = 1'b0; m_have_hi = 1'b0; m_run = 0;
    end else if (s && !p) begin
      m_son = 1'b0; m_soff = 1'b0;
      if (m_have_hi) begin
        b = oot(m_run);
        m_period = m_hi + m_run;
        m_valid = 1'b1;
        m_ok = !(m_hi_bad || b);
        if (b) bump_err();
      end
      m_aligned = 1'b1; m_have_hi = 1'b0; m_run = 1;
    end else if (!s && p) begin
      if (m_aligned && !m_have_hi) begin
        m_hi = m_run; m_hi_bad = oot(m_run); m_have_hi = 1'b1;
        if (m_hi_bad) bump_err();
      end
      m_run = 1;
    end else if (m_run < STUCK) begin
      m_run++;
      if (m_run == STUCK) begin
        if (!s) begin
          m_soff = 1'b1; m_ok = 1'b0; bump_err(); m_aligned = 1'b0; m_have_hi = 1'b0;
        end else if (m_aligned) begin
          m_son = 1'b1; m_ok = 1'b0; bump_err(); m_aligned = 1'b0;
        end
      end
    end
    if (r) {m_l1, m_l2, m_l3} = '0;
    else begin m_l3 = m_l2; m_l2 = m_l1; m_l1 = l; end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit r, input bit l, input bit e);
    rst_i = r; light_i = l; check_en_i = e;
    @(posedge clk);
    model_edge(r, l, e);
    #1;
    if (period_valid_o === 1'b1) begin
      n_pulse++; cap_period = int'(period_o); cap_ok = int'(ok_o); cap_err = int'(err_cnt_o);
    end
    chk("model", 64'({ok_o, stuck_on_o, stuck_off_o, period_valid_o, period_o, err_cnt_o}),
        64'({m_ok, m_son, m_soff, m_valid, 16'(m_period), 8'(m_err)}));
  endtask

  task automatic wave(input int h, input int l);
    for (int i = 0; i < h; i++) cyc(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < l; i++) cyc(1'b0, 1'b0, 1'b1);
  endtask

  task automatic chk_pulse(input string nm, input int np, input int per, input int ok, input int err);
    chk({nm, "_npulse"}, 64'(n_pulse), 64'(np));
    chk({nm, "_period"}, 64'(cap_period), 64'(per));
    chk({nm, "_ok"}, 64'(cap_ok), 64'(ok));
    chk({nm, "_err"}, 64'(cap_err), 64'(err));
  endtask

  typedef struct {
    int h; int l; int pulses; int period; int ok; int err;
  } vec_t;
  vec_t tbl[7];

  initial begin
    int h, lo, dis;
    // Each row: wave played, then the pulse seen during it (reports the previous wave).
    tbl[0] = '{50, 50, 0,   0, 0, 0};
    tbl[1] = '{50, 50, 1, 100, 1, 0};
    tbl[2] = '{52, 48, 1, 100, 1, 0};
    tbl[3] = '{53, 50, 1, 100, 1, 0};
    tbl[4] = '{55, 44, 1, 103, 0, 1};
    tbl[5] = '{50, 50, 1,  99, 0, 3};
    tbl[6] = '{50, 50, 1, 100, 1, 3};

    rst_i = 1'b1; light_i = 1'b0; check_en_i = 1'b1;
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b1);
    chk("reset_outs", 64'({ok_o, stuck_on_o, stuck_off_o, period_valid_o, period_o, err_cnt_o}), 64'd0);
    cyc(1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 7; i++) begin
      n_pulse = 0; cap_period = 0; cap_ok = 0; cap_err = 0;
      wave(tbl[i].h, tbl[i].l);
      chk_pulse("tbl", tbl[i].pulses, tbl[i].period, tbl[i].ok, tbl[i].err);
    end

    // Lamp stuck on after a good period.
    n_pulse = 0;
    for (int i = 1; i <= 250; i++) begin
      cyc(1'b0, 1'b1, 1'b1);
      if (i == 201) chk("son_early", 64'(stuck_on_o), 64'd0);
      if (i == 202) begin
        chk("son_set", 64'(stuck_on_o), 64'd1);
        chk("son_ok", 64'(ok_o), 64'd0);
        chk("son_err", 64'(err_cnt_o), 64'd4);
      end
    end
    chk_pulse("son_prev", 1, 100, 1, 3);
    for (int i = 0; i < 50; i++) cyc(1'b0, 1'b0, 1'b1);
    chk("son_hold", 64'(stuck_on_o), 64'd1);
    n_pulse = 0;
    wave(50, 50);
    chk("son_clear", 64'(stuck_on_o), 64'd0);
    chk("son_realign", 64'(n_pulse), 64'd0);
    wave(50, 50);
    chk_pulse("son_recover", 1, 100, 1, 4);

    // Lamp stuck off from reset.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= 210; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      if (i == 200) chk("soff_early", 64'(stuck_off_o), 64'd0);
      if (i == 201) begin
        chk("soff_set", 64'(stuck_off_o), 64'd1);
        chk("soff_err", 64'(err_cnt_o), 64'd1);
      end
    end
    n_pulse = 0;
    wave(50, 50);
    chk("soff_clear", 64'(stuck_off_o), 64'd0);
    wave(50, 50);
    chk_pulse("soff_recover", 1, 100, 1, 1);

    // Disable mid-HIGH for 30 cycles.
    n_pulse = 0;
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1'b1);
    chk("dis_prev_pulse", 64'(n_pulse), 64'd1);
    for (int i = 0; i < 30; i++) cyc(1'b0, 1'b1, 1'b0);
    chk("dis_no_pulse", 64'(n_pulse), 64'd1);
    chk("dis_period_hold", 64'(period_o), 64'd100);
    chk("dis_ok_clr", 64'(ok_o), 64'd0);
    for (int i = 0; i < 50; i++) cyc(1'b0, 1'b0, 1'b1);
    n_pulse = 0;
    wave(50, 50);
    chk("dis_realign", 64'(n_pulse), 64'd0);
    wave(50, 50);
    chk_pulse("dis_recover", 1, 100, 1, 1);

    // Error counter saturation with short, doubly bad periods.
    for (int i = 0; i < 130; i++) wave(10, 10);
    chk("sat_err", 64'(err_cnt_o), 64'd255);
    wave(10, 10);
    chk("sat_hold", 64'(err_cnt_o), 64'd255);
    chk("sat_ok", 64'(ok_o), 64'd0);

    // Random waves, with occasional stuck-length halves and disables.
    for (int k = 0; k < 40; k++) begin
      h   = int'($urandom_range(44, 56));
      lo  = int'($urandom_range(44, 56));
      if ($urandom_range(0, 9) == 0) h  = int'($urandom_range(190, 230));
      if ($urandom_range(0, 9) == 0) lo = int'($urandom_range(190, 230));
      dis = ($urandom_range(0, 7) == 0) ? 1 : 0;
      for (int i = 0; i < h; i++) cyc(1'b0, 1'b1, !(dis != 0 && i >= 10 && i < 25));
      for (int i = 0; i < lo; i++) cyc(1'b0, 1'b0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/blink_monitor.md
Name: blink_monitor

Overview:
Receive-side companion to the team's lamp-blinker blocks: observes a blinking light line and measures its high and low times. Checks each half-period against a nominal length and tolerance. Flags a lamp stuck on or stuck off, and reports the last measured full period. Sits next to a blinker instance in self-checking top levels, or on a board input for field diagnosis.

Parameters:
HALF_CYC, 50, nominal high time and nominal low time, in clk_i cycles (>= 4)
TOL_CYC, 2, allowed deviation of each half-period, +/- cycles (< HALF_CYC)
STUCK_CYC, 200, length of an unchanged level that declares the lamp stuck (> HALF_CYC+TOL_CYC)
CNT_W, 16, width of the internal counters and of period_o (must hold 2*STUCK_CYC)

Ports:
clk_i  in  1  single clock
rst_i  in  1  synchronous, active-high reset
light_i  in  1  observed lamp line; may be asynchronous
check_en_i  in  1  1 = monitor active; 0 = idle
ok_o  out  1  1 = last full period had both halves within tolerance
stuck_on_o  out  1  lamp held 1 for STUCK_CYC cycles
stuck_off_o  out  1  lamp held 0 for STUCK_CYC cycles
period_o  out  CNT_W  last measured high_len+low_len
period_valid_o  out  1  one-cycle pulse when period_o/ok_o update
err_cnt_o  out  8  saturating count of tolerance violations and stuck events

Behaviour:
Reset
- rst_i=1 at a clock edge: synchronizer, edge register, counters and all outputs go to 0; FSM goes to IDLE.
- Reset mid-measurement discards the partial count.

Input path
- light_i passes a 2-FF synchronizer (reset 0), then a delay register.
- rise = sync & ~prev; fall = ~sync & prev.
- All outputs are registered.
- Latency: period_valid_o is high in the cycle after the 3rd clock edge that samples the new light_i level.

FSM states: IDLE, ALIGN, HIGH, LOW
- IDLE: counters held at 0. Go to ALIGN when check_en_i=1.
- ALIGN: wait for the first rise. cnt counts cycles of the 0 level. Go to HIGH on rise (cnt loads 1). Produce no period from a partial first pulse.
- HIGH: cnt increments while sync=1.
  - On fall: high_len=cnt; flag violation if |high_len-HALF_CYC| > TOL_CYC; go to LOW with cnt=1.
- LOW: cnt increments while sync=0.
  - On rise: low_len=cnt; run the same check.
  - period_o <= high_len+low_len; period_valid_o pulses.
  - ok_o <= no violation in either half; go to HIGH with cnt=1.
- Each half-period is checked independently. err_cnt_o increments once per violating half, so +2 if both halves are out of tolerance in one period.

Stuck detection
- cnt reaching STUCK_CYC in HIGH sets stuck_on_o. In LOW or ALIGN it sets stuck_off_o.
- On that event: ok_o <= 0, err_cnt_o +1 (once only), cnt saturates at STUCK_CYC, FSM goes to ALIGN (the stuck-on case waits for fall, then rise).
- A stuck flag clears at the next rise. ok_o recovers only after one full good period.

Disable and saturation
- check_en_i=0 in any state: next state IDLE.
- ok_o, stuck_on_o, stuck_off_o and period_valid_o clear; period_o and err_cnt_o hold.
- err_cnt_o saturates at 255.
- A rise and check_en_i falling in the same cycle: the disable wins and no pulse is produced.

Decomposition:
- Package blink_mon_pkg: FSM state enum (IDLE, ALIGN, HIGH, LOW) and the err_cnt width constant.
- Sub-module sync_edge_det: 2-FF synchronizer, delay register, rise/fall outputs. Reused by future board-input blocks.

Test Plan:
1. Reset held 5 cycles, check_en_i=1, square wave 50 high/50 low -> first period_valid_o after the 2nd rise; period_o=100, ok_o=1, err_cnt_o=0, no stuck flags.
2. Wave 52 high/48 low -> period_o=100, ok_o=1; then 53 high/50 low -> ok_o=0, err_cnt_o=1.
3. Wave 55 high/44 low -> ok_o=0, err_cnt_o increments by 2.
4. light_i held 1 for 250 cycles after a good period -> stuck_on_o=1 exactly 200 cycles after the last rise; ok_o=0; err_cnt_o+1; flag clears at the next rise; ok_o=1 after the following good period.
5. light_i held 0 from reset -> stuck_off_o=1 at 200 cycles into ALIGN; a later 50/50 wave clears it.
6. Deassert check_en_i mid-HIGH for 30 cycles, then reassert -> no period_valid_o while disabled; period_o held; the first new pulse only re-aligns; the next period is reported correctly.
